control_unit: RTL and testbench
===============================

# control_unit

Moore-style sequencer that drives the CPU datapath's control inputs, so the datapath no longer has to be stepped by hand from a bench. Each instruction runs as a common three-cycle fetch followed by a per-class execute sequence. The opcode comes from `IR_Data[31:27]`. The block sits beside the datapath and connects port-for-port to its enable, select, ALU-opcode and memory-strobe inputs.

## Interface
- `ADD_OP`, default 5'b00011: ALU opcode used for effective-address and branch-target adds.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `IR_Data`  in  32: instruction register; opcode is `[31:27]`.
- `con_ff`  in  1: branch condition flip-flop output from the datapath.
- `stop`  in  1: level request to pause at the next instruction boundary.
- Register enables, each `out 1`: `PC_enable`, `PC_increment_enable`, `IR_enable`, `Y_enable`, `Z_enable`, `MAR_enable`, `MDR_enable`, `r_enable`, `CON_enable`.
- Memory strobes, each `out 1`: `read`, `write`.
- Register-select controls, each `out 1`: `Gra`, `Grb`, `Grc`, `ba_select`.
- Bus-source selects, each `out 1`: `PC_select`, `Z_LO_select`, `MDR_select`, `c_select`, `r_select`.
- `alu_instruction`  out  5: ALU opcode.
- `run`  out  1: high while executing; low in `RESET_ST`, `PAUSED` and `HALTED`.

## Operation
- **Output rule:** every output is a pure function of state. Outputs are 0 unless listed for a state. `alu_instruction` is `IR_Data[31:27]` unless `ADD_OP` is listed.
- **Fetch sequence:**
  - `FETCH0`: `PC_select`, `MAR_enable`.
  - `FETCH1`: `PC_increment_enable`, `read`, `MDR_enable`.
  - `FETCH2`: `MDR_select`, `IR_enable`.
  - Class dispatch on the opcode happens at the end of `FETCH2`.
- **ALU3** (add 00011, sub 00100, and 01010, or 01011):
  - T3: `Grb`, `r_select`, `Y_enable`.
  - T4: `Grc`, `r_select`, `Z_enable`.
  - T5: `Z_LO_select`, `Gra`, `r_enable`.
- **IMM** (addi 01100, andi 01101, ori 01110):
  - T3: `Grb`, `r_select`, `Y_enable`.
  - T4: `c_select`, `Z_enable`.
  - T5: as ALU3.
- **LDI** (00001):
  - T3: `Grb`, `ba_select`, `Y_enable`.
  - T4: `c_select`, `Z_enable`.
  - T5: as ALU3.
- **LD** (00000):
  - T3: as LDI.
  - T4: as LDI, with `alu_instruction=ADD_OP`.
  - T5: `Z_LO_select`, `MAR_enable`.
  - T6: `read`, `MDR_enable`.
  - T7: `MDR_select`, `Gra`, `r_enable`.
- **ST** (00010):
  - T3–T5: as LD.
  - T6: `Gra`, `r_select`, `MDR_enable` (`read`=0, so MDR loads from the bus).
  - T7: `write`.
- **BR** (10011):
  - T3: `Gra`, `r_select`, `CON_enable`.
  - T4: `PC_select`, `Y_enable`.
  - T5: `c_select`, `Z_enable`, `alu_instruction=ADD_OP`.
  - T6: `Z_LO_select`; `PC_enable` only if `con_ff`=1.
- **NOP and unknown opcodes:** go from `FETCH2` straight to `FETCH0`.
- **HALT** (11011): go to `HALTED`, which holds until `reset`.
- **stop:** sampled only on the edge that would enter `FETCH0`. If `stop`=1, enter `PAUSED` instead. Leave `PAUSED` for `FETCH0` on the first edge with `stop`=0.
- The last execute state always returns to `FETCH0`.

## Timing
- One state per clock. Registers capture on the rising edge that ends the state in which their enable is high.
- The datapath captures `con_ff` at the end of BR T3, so it is stable through T6.
- Cycle counts, fetch included:
  - NOP: 3.
  - ALU3, IMM, LDI: 6.
  - BR: 7.
  - LD, ST: 8.
- Asserting `reset` asynchronously forces `RESET_ST`, with all outputs 0 immediately and no clock edge needed. This applies mid-instruction too; the aborted instruction has no further strobes.
- The first rising edge with `reset`=0 enters `FETCH0` (subject to `stop`).
- `write` and `read` are never high together. `r_enable` is never high in the same state as `Grc`.
- `IR_Data` must stay stable from the end of `FETCH2` until the next `FETCH2`. The unit does not latch it.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (5-bit) for all opcodes above;
  - state enum covering `RESET_ST`, `FETCH0..2`, `T3..T7`, `PAUSED`, `HALTED`;
  - instruction-class enum (ALU3, IMM, LDI, LD, ST, BR, NOP, HALT).
- Optional sub-module `instr_class_decode`: combinational, opcode to class.
- State register and output decode live in `control_unit`.

## Test plan
- Reset, then IR opcode 00001 (LDI): states `FETCH0`…T5 over 6 cycles; T4 has `alu_instruction`=00001 and `c_select`; `r_enable` high only in T5; `FETCH0` again on cycle 7.
- Opcode 01101 (ANDI): T3 has `Grb`+`r_select`; T4 has `alu_instruction`=01101, `c_select`, `Z_enable`; `run`=1 throughout.
- Opcode 00000 (LD): 8 cycles; T4 has `alu_instruction`=00011; `MAR_enable` only in T5; `read`+`MDR_enable` in T6. Then opcode 00010 (ST): `write` only in T7 and `read` never high.
- BR with `con_ff`=0: `PC_enable` never high. Repeat with `con_ff`=1: `PC_enable` high in exactly one cycle (T6).
- Opcode 11011 (HALT): `run`=0 from the cycle after `FETCH2` and stays 0 for 20 clocks. Assert `reset`: outputs 0. Release: `FETCH0` with `PC_select`=1.
- Assert `reset` midway through LD T5: `MAR_enable` drops to 0 before the next edge. Hold `stop`=1 at the end of an ADD: `PAUSED` with `run`=0. Drop `stop`: `FETCH0` on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the CPU control unit and its opcode decoder.
//   - 5-bit opcode constants for every opcode the sequencer recognises
//   - state_e        : sequencer states (reset, fetch, execute steps, pause/halt)
//   - instr_class_e  : execute-sequence class chosen at the end of FETCH2
//   - alu_src_e      : where the alu_instruction output is taken from
//   - ctrl_t         : one bundle holding every datapath control output
//   - ctrl_base()    : starting value for a state's control bundle
//   - is_short_exec(): classes whose execute sequence ends after T5
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes, IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    RESET_ST = 4'd0,
    FETCH0   = 4'd1,
    FETCH1   = 4'd2,
    FETCH2   = 4'd3,
    T3       = 4'd4,
    T4       = 4'd5,
    T5       = 4'd6,
    T6       = 4'd7,
    T7       = 4'd8,
    PAUSED   = 4'd9,
    HALTED   = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU3 = 3'd0,
    CLS_IMM  = 3'd1,
    CLS_LDI  = 3'd2,
    CLS_LD   = 3'd3,
    CLS_ST   = 3'd4,
    CLS_BR   = 3'd5,
    CLS_NOP  = 3'd6,
    CLS_HALT = 3'd7
  } instr_class_e;

  typedef enum logic [1:0] {
    ALU_SRC_ZERO = 2'd0,  // reset: every output must read 0
    ALU_SRC_IR   = 2'd1,  // pass the opcode straight through
    ALU_SRC_ADD  = 2'd2   // force an add for address/branch-target sums
  } alu_src_e;

  typedef struct packed {
    logic     pc_enable;
    logic     pc_increment_enable;
    logic     ir_enable;
    logic     y_enable;
    logic     z_enable;
    logic     mar_enable;
    logic     mdr_enable;
    logic     r_enable;
    logic     con_enable;
    logic     read;
    logic     write;
    logic     gra;
    logic     grb;
    logic     grc;
    logic     ba_select;
    logic     pc_select;
    logic     z_lo_select;
    logic     mdr_select;
    logic     c_select;
    logic     r_select;
    alu_src_e alu_src;
    logic     run;
  } ctrl_t;

  // All strobes low and the ALU opcode forced to zero.
  localparam ctrl_t CTRL_IDLE = '0;

  // Quiet bundle for any non-reset state: no strobes, opcode passed through.
  function automatic ctrl_t ctrl_base(input logic running);
    ctrl_t c;
    c         = CTRL_IDLE;
    c.alu_src = ALU_SRC_IR;
    c.run     = running;
    return c;
  endfunction

  // ALU3, IMM and LDI write their result in T5 and are finished there.
  function automatic logic is_short_exec(input instr_class_e cls);
    logic short_s;
    case (cls)
      CLS_ALU3, CLS_IMM, CLS_LDI: short_s = 1'b1;
      default:                    short_s = 1'b0;
    endcase
    return short_s;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// -----------------------------------------------------------------------------
// instr_class_decode
// Combinational opcode-to-class map used to pick the execute sequence.
// Any opcode that is not recognised is treated as a NOP so the sequencer
// simply fetches the next instruction.
//   opcode      in  5 : IR[31:27]
//   instr_class out   : execute-sequence class
// -----------------------------------------------------------------------------
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_e instr_class
);

  // Opcode lookup; unlisted codes fall through to NOP.
  always_comb begin
    instr_class = CLS_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: instr_class = CLS_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:      instr_class = CLS_IMM;
      OP_LDI:                        instr_class = CLS_LDI;
      OP_LD:                         instr_class = CLS_LD;
      OP_ST:                         instr_class = CLS_ST;
      OP_BR:                         instr_class = CLS_BR;
      OP_HALT:                       instr_class = CLS_HALT;
      OP_NOP:                        instr_class = CLS_NOP;
      default:                       instr_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Moore sequencer driving the CPU datapath. Every instruction runs a common
// FETCH0..FETCH2 then a class-specific execute sequence (T3..T7). The control
// bundle is registered together with the state: on each edge the bundle for
// the state being entered is computed and captured, so outputs never glitch
// and an asynchronous reset clears them at once.
//
// Parameters
//   ADD_OP               : ALU opcode used for address and branch-target adds
// Ports
//   clk                  in  1  : rising-edge clock
//   reset                in  1  : asynchronous, active-high
//   IR_Data              in  32 : instruction register, opcode in [31:27]
//   con_ff               in  1  : branch condition from the datapath
//   stop                 in  1  : pause request, honoured at instruction boundary
//   PC_enable .. CON_enable out : register load enables
//   read, write             out : memory strobes
//   Gra, Grb, Grc, ba_select out: register-file select controls
//   PC_select .. r_select   out : bus source selects
//   alu_instruction      out 5  : ALU opcode
//   run                  out 1  : high while the sequencer is executing
// -----------------------------------------------------------------------------
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_Data,
  input  logic        con_ff,
  input  logic        stop,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        CON_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        ba_select,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic        r_select,
  output logic [4:0]  alu_instruction,
  output logic        run
);

  state_e       state_r;
  state_e       next_state_s;
  state_e       fetch_entry_s;
  instr_class_e class_s;
  ctrl_t        ctrl_r;
  ctrl_t        ctrl_next_s;
  logic [4:0]   opcode_s;
  logic         ir_unused_s;

  assign opcode_s    = IR_Data[31:27];
  // Operand fields belong to the datapath; only the opcode matters here.
  assign ir_unused_s = ^IR_Data[26:0];

  instr_class_decode u_class_decode (
    .opcode      (opcode_s),
    .instr_class (class_s)
  );

  // Instruction boundary: a pending stop diverts into PAUSED instead of FETCH0.
  always_comb begin
    if (stop) begin
      fetch_entry_s = PAUSED;
    end else begin
      fetch_entry_s = FETCH0;
    end
  end

  // Next-state sequencing; IR is decoded live since it is stable through execute.
  always_comb begin
    next_state_s = RESET_ST;
    case (state_r)
      RESET_ST: next_state_s = fetch_entry_s;
      FETCH0:   next_state_s = FETCH1;
      FETCH1:   next_state_s = FETCH2;
      FETCH2: begin
        case (class_s)
          CLS_NOP:  next_state_s = fetch_entry_s;
          CLS_HALT: next_state_s = HALTED;
          default:  next_state_s = T3;
        endcase
      end
      T3:       next_state_s = T4;
      T4:       next_state_s = T5;
      T5: begin
        if (is_short_exec(class_s)) begin
          next_state_s = fetch_entry_s;
        end else begin
          next_state_s = T6;
        end
      end
      T6: begin
        case (class_s)
          CLS_LD, CLS_ST: next_state_s = T7;
          default:        next_state_s = fetch_entry_s;
        endcase
      end
      T7:       next_state_s = fetch_entry_s;
      PAUSED: begin
        if (stop) begin
          next_state_s = PAUSED;
        end else begin
          next_state_s = FETCH0;
        end
      end
      HALTED:   next_state_s = HALTED;
      default:  next_state_s = RESET_ST;
    endcase
  end

  // Control bundle for the state about to be entered.
  always_comb begin
    ctrl_next_s = ctrl_base(1'b1);
    case (next_state_s)
      RESET_ST: ctrl_next_s = CTRL_IDLE;
      FETCH0: begin
        ctrl_next_s.pc_select  = 1'b1;
        ctrl_next_s.mar_enable = 1'b1;
      end
      FETCH1: begin
        ctrl_next_s.pc_increment_enable = 1'b1;
        ctrl_next_s.read                = 1'b1;
        ctrl_next_s.mdr_enable          = 1'b1;
      end
      FETCH2: begin
        ctrl_next_s.mdr_select = 1'b1;
        ctrl_next_s.ir_enable  = 1'b1;
      end
      T3: begin
        case (class_s)
          CLS_ALU3, CLS_IMM: begin
            ctrl_next_s.grb      = 1'b1;
            ctrl_next_s.r_select = 1'b1;
            ctrl_next_s.y_enable = 1'b1;
          end
          // Base register through the R0-as-zero path for address forming.
          CLS_LDI, CLS_LD, CLS_ST: begin
            ctrl_next_s.grb       = 1'b1;
            ctrl_next_s.ba_select = 1'b1;
            ctrl_next_s.y_enable  = 1'b1;
          end
          CLS_BR: begin
            ctrl_next_s.gra        = 1'b1;
            ctrl_next_s.r_select   = 1'b1;
            ctrl_next_s.con_enable = 1'b1;
          end
          default: ctrl_next_s = ctrl_base(1'b1);
        endcase
      end
      T4: begin
        case (class_s)
          CLS_ALU3: begin
            ctrl_next_s.grc      = 1'b1;
            ctrl_next_s.r_select = 1'b1;
            ctrl_next_s.z_enable = 1'b1;
          end
          CLS_IMM, CLS_LDI: begin
            ctrl_next_s.c_select = 1'b1;
            ctrl_next_s.z_enable = 1'b1;
          end
          // LD/ST opcodes are not adds, so the effective address forces one.
          CLS_LD, CLS_ST: begin
            ctrl_next_s.c_select = 1'b1;
            ctrl_next_s.z_enable = 1'b1;
            ctrl_next_s.alu_src  = ALU_SRC_ADD;
          end
          CLS_BR: begin
            ctrl_next_s.pc_select = 1'b1;
            ctrl_next_s.y_enable  = 1'b1;
          end
          default: ctrl_next_s = ctrl_base(1'b1);
        endcase
      end
      T5: begin
        case (class_s)
          CLS_ALU3, CLS_IMM, CLS_LDI: begin
            ctrl_next_s.z_lo_select = 1'b1;
            ctrl_next_s.gra         = 1'b1;
            ctrl_next_s.r_enable    = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl_next_s.z_lo_select = 1'b1;
            ctrl_next_s.mar_enable  = 1'b1;
          end
          CLS_BR: begin
            ctrl_next_s.c_select = 1'b1;
            ctrl_next_s.z_enable = 1'b1;
            ctrl_next_s.alu_src  = ALU_SRC_ADD;
          end
          default: ctrl_next_s = ctrl_base(1'b1);
        endcase
      end
      T6: begin
        case (class_s)
          CLS_LD: begin
            ctrl_next_s.read       = 1'b1;
            ctrl_next_s.mdr_enable = 1'b1;
          end
          // read stays low so MDR takes the store data from the bus.
          CLS_ST: begin
            ctrl_next_s.gra        = 1'b1;
            ctrl_next_s.r_select   = 1'b1;
            ctrl_next_s.mdr_enable = 1'b1;
          end
          // con_ff was captured at the end of T3 and is stable here.
          CLS_BR: begin
            ctrl_next_s.z_lo_select = 1'b1;
            ctrl_next_s.pc_enable   = con_ff;
          end
          default: ctrl_next_s = ctrl_base(1'b1);
        endcase
      end
      T7: begin
        case (class_s)
          CLS_LD: begin
            ctrl_next_s.mdr_select = 1'b1;
            ctrl_next_s.gra        = 1'b1;
            ctrl_next_s.r_enable   = 1'b1;
          end
          CLS_ST:  ctrl_next_s.write = 1'b1;
          default: ctrl_next_s = ctrl_base(1'b1);
        endcase
      end
      PAUSED:  ctrl_next_s = ctrl_base(1'b0);
      HALTED:  ctrl_next_s = ctrl_base(1'b0);
      default: ctrl_next_s = CTRL_IDLE;
    endcase
  end

  // State and control bundle registers; reset clears both with no clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RESET_ST;
      ctrl_r  <= CTRL_IDLE;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= ctrl_next_s;
    end
  end

  // ALU opcode source select.
  always_comb begin
    case (ctrl_r.alu_src)
      ALU_SRC_ZERO: alu_instruction = 5'b00000;
      ALU_SRC_ADD:  alu_instruction = ADD_OP;
      ALU_SRC_IR:   alu_instruction = opcode_s;
      default:      alu_instruction = 5'b00000;
    endcase
  end

  assign PC_enable           = ctrl_r.pc_enable;
  assign PC_increment_enable = ctrl_r.pc_increment_enable;
  assign IR_enable           = ctrl_r.ir_enable;
  assign Y_enable            = ctrl_r.y_enable;
  assign Z_enable            = ctrl_r.z_enable;
  assign MAR_enable          = ctrl_r.mar_enable;
  assign MDR_enable          = ctrl_r.mdr_enable;
  assign r_enable            = ctrl_r.r_enable;
  assign CON_enable          = ctrl_r.con_enable;
  assign read                = ctrl_r.read;
  assign write               = ctrl_r.write;
  assign Gra                 = ctrl_r.gra;
  assign Grb                 = ctrl_r.grb;
  assign Grc                 = ctrl_r.grc;
  assign ba_select           = ctrl_r.ba_select;
  assign PC_select           = ctrl_r.pc_select;
  assign Z_LO_select         = ctrl_r.z_lo_select;
  assign MDR_select          = ctrl_r.mdr_select;
  assign c_select            = ctrl_r.c_select;
  assign r_select            = ctrl_r.r_select;
  assign run                 = ctrl_r.run;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Directed bench for control_unit. For each instruction issued, an expected
// per-cycle output trace is built from the instruction's class and queued;
// one compare process pops an entry after every rising edge and checks it.
// Literal spot checks on captured cycles pin the trace model itself.
// -----------------------------------------------------------------------------
module tb_control_unit;

  localparam logic [4:0] O_LD   = 5'b00000;
  localparam logic [4:0] O_LDI  = 5'b00001;
  localparam logic [4:0] O_ST   = 5'b00010;
  localparam logic [4:0] O_ADD  = 5'b00011;
  localparam logic [4:0] O_SUB  = 5'b00100;
  localparam logic [4:0] O_AND  = 5'b01010;
  localparam logic [4:0] O_OR   = 5'b01011;
  localparam logic [4:0] O_ADDI = 5'b01100;
  localparam logic [4:0] O_ANDI = 5'b01101;
  localparam logic [4:0] O_ORI  = 5'b01110;
  localparam logic [4:0] O_BR   = 5'b10011;
  localparam logic [4:0] O_NOP  = 5'b11010;
  localparam logic [4:0] O_HALT = 5'b11011;
  localparam logic [4:0] O_UNK  = 5'b11111;

  // Bit positions of the packed control vector below.
  localparam logic [19:0] M_PCEN   = 20'h00001;
  localparam logic [19:0] M_PCINC  = 20'h00002;
  localparam logic [19:0] M_IR     = 20'h00004;
  localparam logic [19:0] M_Y      = 20'h00008;
  localparam logic [19:0] M_Z      = 20'h00010;
  localparam logic [19:0] M_MAR    = 20'h00020;
  localparam logic [19:0] M_MDR    = 20'h00040;
  localparam logic [19:0] M_REN    = 20'h00080;
  localparam logic [19:0] M_CON    = 20'h00100;
  localparam logic [19:0] M_RD     = 20'h00200;
  localparam logic [19:0] M_WR     = 20'h00400;
  localparam logic [19:0] M_GRA    = 20'h00800;
  localparam logic [19:0] M_GRB    = 20'h01000;
  localparam logic [19:0] M_GRC    = 20'h02000;
  localparam logic [19:0] M_BA     = 20'h04000;
  localparam logic [19:0] M_PCSEL  = 20'h08000;
  localparam logic [19:0] M_ZLO    = 20'h10000;
  localparam logic [19:0] M_MDRSEL = 20'h20000;
  localparam logic [19:0] M_CSEL   = 20'h40000;
  localparam logic [19:0] M_RSEL   = 20'h80000;

  localparam logic [1:0] K_IR   = 2'd0;
  localparam logic [1:0] K_ADD  = 2'd1;
  localparam logic [1:0] K_ZERO = 2'd2;

  typedef struct packed {
    logic [19:0] ctl;
    logic [1:0]  alu_kind;
    logic        run;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] IR_Data;
  logic        con_ff;
  logic        stop;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic MAR_enable, MDR_enable, r_enable, CON_enable, read, write;
  logic Gra, Grb, Grc, ba_select, PC_select, Z_LO_select, MDR_select;
  logic c_select, r_select, run;
  logic [4:0]  alu_instruction;
  logic [19:0] ctl_s;

  exp_t        exp_q[$];
  exp_t        cmp_e;
  logic [4:0]  cmp_alu;
  int          n_cmp;
  int          n_bad;
  logic [19:0] snap_ctl[0:15];
  logic [4:0]  snap_alu[0:15];
  logic        snap_run[0:15];

  control_unit #(.ADD_OP(5'b00011)) dut (
    .clk                 (clk),
    .reset               (reset),
    .IR_Data             (IR_Data),
    .con_ff              (con_ff),
    .stop                (stop),
    .PC_enable           (PC_enable),
    .PC_increment_enable (PC_increment_enable),
    .IR_enable           (IR_enable),
    .Y_enable            (Y_enable),
    .Z_enable            (Z_enable),
    .MAR_enable          (MAR_enable),
    .MDR_enable          (MDR_enable),
    .r_enable            (r_enable),
    .CON_enable          (CON_enable),
    .read                (read),
    .write               (write),
    .Gra                 (Gra),
    .Grb                 (Grb),
    .Grc                 (Grc),
    .ba_select           (ba_select),
    .PC_select           (PC_select),
    .Z_LO_select         (Z_LO_select),
    .MDR_select          (MDR_select),
    .c_select            (c_select),
    .r_select            (r_select),
    .alu_instruction     (alu_instruction),
    .run                 (run)
  );

  assign ctl_s = {r_select, c_select, MDR_select, Z_LO_select, PC_select,
                  ba_select, Grc, Grb, Gra, write, read, CON_enable, r_enable,
                  MDR_enable, MAR_enable, Z_enable, Y_enable, IR_enable,
                  PC_increment_enable, PC_enable};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  // Trace compare, 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      case (cmp_e.alu_kind)
        K_ADD:   cmp_alu = 5'b00011;
        K_ZERO:  cmp_alu = 5'b00000;
        default: cmp_alu = IR_Data[31:27];
      endcase
      n_cmp = n_cmp + 1;
      if (ctl_s !== cmp_e.ctl || alu_instruction !== cmp_alu || run !== cmp_e.run) begin
        n_bad = n_bad + 1;
        $display("FAIL trace @%0t: ctl got %05h exp %05h, alu got %05b exp %05b, run got %b exp %b",
                 $time, ctl_s, cmp_e.ctl, alu_instruction, cmp_alu, run, cmp_e.run);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_e(input logic [19:0] ctl, input logic [1:0] kind, input logic r);
    exp_t e;
    e.ctl      = ctl;
    e.alu_kind = kind;
    e.run      = r;
    exp_q.push_back(e);
  endtask

  // Expected cycle-by-cycle trace of one instruction, fetch included.
  task automatic push_trace(input logic [4:0] op, input logic con);
    push_e(M_PCSEL | M_MAR, K_IR, 1'b1);
    push_e(M_PCINC | M_RD | M_MDR, K_IR, 1'b1);
    push_e(M_MDRSEL | M_IR, K_IR, 1'b1);
    case (op)
      O_ADD, O_SUB, O_AND, O_OR: begin
        push_e(M_GRB | M_RSEL | M_Y, K_IR, 1'b1);
        push_e(M_GRC | M_RSEL | M_Z, K_IR, 1'b1);
        push_e(M_ZLO | M_GRA | M_REN, K_IR, 1'b1);
      end
      O_ADDI, O_ANDI, O_ORI: begin
        push_e(M_GRB | M_RSEL | M_Y, K_IR, 1'b1);
        push_e(M_CSEL | M_Z, K_IR, 1'b1);
        push_e(M_ZLO | M_GRA | M_REN, K_IR, 1'b1);
      end
      O_LDI: begin
        push_e(M_GRB | M_BA | M_Y, K_IR, 1'b1);
        push_e(M_CSEL | M_Z, K_IR, 1'b1);
        push_e(M_ZLO | M_GRA | M_REN, K_IR, 1'b1);
      end
      O_LD, O_ST: begin
        push_e(M_GRB | M_BA | M_Y, K_IR, 1'b1);
        push_e(M_CSEL | M_Z, K_ADD, 1'b1);
        push_e(M_ZLO | M_MAR, K_IR, 1'b1);
        if (op == O_LD) begin
          push_e(M_RD | M_MDR, K_IR, 1'b1);
          push_e(M_MDRSEL | M_GRA | M_REN, K_IR, 1'b1);
        end else begin
          push_e(M_GRA | M_RSEL | M_MDR, K_IR, 1'b1);
          push_e(M_WR, K_IR, 1'b1);
        end
      end
      O_BR: begin
        push_e(M_GRA | M_RSEL | M_CON, K_IR, 1'b1);
        push_e(M_PCSEL | M_Y, K_IR, 1'b1);
        push_e(M_CSEL | M_Z, K_ADD, 1'b1);
        push_e(M_ZLO | (con ? M_PCEN : 20'h00000), K_IR, 1'b1);
      end
      default: ;
    endcase
  endtask

  // Issue one instruction from a falling edge just before FETCH0; IR and
  // con_ff change after FETCH0 is sampled. Returns on the falling edge of
  // the last cycle stepped, with per-cycle snapshots captured.
  task automatic run_instr(input logic [4:0] op, input logic con, input int exp_len, input int steps);
    int len;
    check("queue_empty_before_issue", exp_q.size(), 0);
    push_trace(op, con);
    len = exp_q.size();
    check("trace_length", len, exp_len);
    for (int i = 0; i < steps; i++) begin
      @(negedge clk);
      snap_ctl[i] = ctl_s;
      snap_alu[i] = alu_instruction;
      snap_run[i] = run;
      if (i == 0) begin
        IR_Data = {op, 27'h1234567};
        con_ff  = con;
      end
    end
  endtask

  // Asynchronous reset pulse starting mid-cycle, held two edges.
  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    check("reset_async_ctl", ctl_s, 0);
    check("reset_async_alu", alu_instruction, 0);
    check("reset_async_run", run, 0);
    push_e(20'h00000, K_ZERO, 1'b0);
    push_e(20'h00000, K_ZERO, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    stop    = 1'b0;
    con_ff  = 1'b0;
    IR_Data = {O_NOP, 27'h0};
    repeat (3) @(negedge clk);
    check("reset_ctl", ctl_s, 0);
    check("reset_alu", alu_instruction, 0);
    check("reset_run", run, 0);
    reset = 1'b0;

    // LDI
    run_instr(O_LDI, 1'b0, 6, 6);
    check("ldi_f0_pcsel", snap_ctl[0], M_PCSEL | M_MAR);
    check("ldi_t4_alu", snap_alu[4], 5'b00001);
    check("ldi_t4_csel", snap_ctl[4][18], 1);
    for (int i = 0; i < 6; i++) check("ldi_r_enable", snap_ctl[i][7], (i == 5));

    // ANDI
    run_instr(O_ANDI, 1'b0, 6, 6);
    check("ldi_refetch_f0", snap_ctl[0], M_PCSEL | M_MAR);
    check("andi_t3", snap_ctl[3], M_GRB | M_RSEL | M_Y);
    check("andi_t4", snap_ctl[4], M_CSEL | M_Z);
    check("andi_t4_alu", snap_alu[4], 5'b01101);
    for (int i = 0; i < 6; i++) check("andi_run", snap_run[i], 1);

    run_instr(O_ADD, 1'b0, 6, 6);
    check("add_t4", snap_ctl[4], M_GRC | M_RSEL | M_Z);
    run_instr(O_SUB, 1'b0, 6, 6);
    run_instr(O_OR, 1'b0, 6, 6);
    run_instr(O_ORI, 1'b0, 6, 6);

    // LD then ST
    run_instr(O_LD, 1'b0, 8, 8);
    check("ld_t4_alu", snap_alu[4], 5'b00011);
    for (int i = 3; i < 8; i++) check("ld_mar_only_t5", snap_ctl[i][5], (i == 5));
    check("ld_t6", snap_ctl[6], M_RD | M_MDR);
    run_instr(O_ST, 1'b0, 8, 8);
    for (int i = 0; i < 8; i++) check("st_write_t7", snap_ctl[i][10], (i == 7));
    for (int i = 3; i < 8; i++) check("st_no_read", snap_ctl[i][9], 0);

    run_instr(O_NOP, 1'b0, 3, 3);
    run_instr(O_UNK, 1'b0, 3, 3);

    // Branch not taken / taken
    run_instr(O_BR, 1'b0, 7, 7);
    for (int i = 0; i < 7; i++) check("br0_no_pc_enable", snap_ctl[i][0], 0);
    run_instr(O_BR, 1'b1, 7, 7);
    for (int i = 0; i < 7; i++) check("br1_pc_enable_t6", snap_ctl[i][0], (i == 6));
    check("br1_t5_alu", snap_alu[5], 5'b00011);

    // stop at the end of an ADD
    run_instr(O_ADD, 1'b0, 6, 6);
    stop = 1'b1;
    repeat (3) push_e(20'h00000, K_IR, 1'b0);
    repeat (3) @(negedge clk);
    check("paused_run", run, 0);
    stop = 1'b0;
    run_instr(O_NOP, 1'b0, 3, 3);
    check("unpause_f0", snap_ctl[0], M_PCSEL | M_MAR);
    check("unpause_run", snap_run[0], 1);

    // Reset in the middle of LD T5
    run_instr(O_LD, 1'b0, 8, 6);
    check("ld_t5_mar_before_reset", snap_ctl[5][5], 1);
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("midreset_mar", MAR_enable, 0);
    reset = 1'b0;
    reset_pulse();

    run_instr(O_LDI, 1'b0, 6, 6);

    // HALT holds for 20 clocks, then reset and restart
    run_instr(O_HALT, 1'b0, 3, 3);
    repeat (20) push_e(20'h00000, K_IR, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_run_low", run, 0);
    end
    reset_pulse();
    run_instr(O_LDI, 1'b0, 6, 6);
    check("post_halt_pcsel", snap_ctl[0][15], 1);
    check("post_halt_run", snap_run[0], 1);

    @(negedge clk);
    check("trace_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
